// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: data width, ALU
// function codes, FSM state encoding and the captured-operation record.
package alu_arbiter_pkg;

  localparam int unsigned DW = 6;
  localparam int unsigned FW = 3;

  typedef enum logic [FW-1:0] {
    FXN_PASS_A = 3'b000,
    FXN_PASS_B = 3'b001,
    FXN_NEG_A  = 3'b010,
    FXN_NEG_B  = 3'b011,
    FXN_SLT    = 3'b100,
    FXN_XNOR   = 3'b101,
    FXN_ADD    = 3'b110,
    FXN_SUB    = 3'b111
  } fxn_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    fxn_t          fxn;
    logic          id;
  } op_t;

endpackage

// File: rtl/alu_arbiter_mini_alu.sv
// MINI_ALU: purely combinational 6-bit two's-complement ALU, results wrap
// modulo 2^DW.
module alu_arbiter_mini_alu
  import alu_arbiter_pkg::*;
(
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  fxn_t          fxn,
  output logic [DW-1:0] y
);

  always_comb begin
    y = '0;
    case (fxn)
      FXN_PASS_A: y = a;
      FXN_PASS_B: y = b;
      FXN_NEG_A:  y = '0 - a;
      FXN_NEG_B:  y = '0 - b;
      FXN_SLT:    y = {{(DW-1){1'b0}}, ($signed(a) < $signed(b))};
      FXN_XNOR:   y = ~(a ^ b);
      FXN_ADD:    y = a + b;
      FXN_SUB:    y = a - b;
      default:    y = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a single MINI_ALU, one operation in flight.
// Optional ALU_ARB_FLAGS_EN adds registered rsp_zero/rsp_neg result flags.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned FAIR = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [DW-1:0] req0_a,
  input  logic [DW-1:0] req0_b,
  input  logic [FW-1:0] req0_fxn,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [DW-1:0] req1_a,
  input  logic [DW-1:0] req1_b,
  input  logic [FW-1:0] req1_fxn,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_id
`ifdef ALU_ARB_FLAGS_EN
  ,
  output logic          rsp_zero,
  output logic          rsp_neg
`endif
);

  state_t        state, state_nxt;
  op_t           op_q, op_sel;
  logic          last_grant;
  logic          grant1;
  logic          accept;
  logic [DW-1:0] alu_y;

  always_comb begin
    grant1 = req1_valid;
    if (req0_valid && req1_valid) begin
      grant1 = (FAIR != 0) ? !last_grant : 1'b0;
    end
  end

  // Ready is gated by rst_n so it drops the instant reset asserts.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (rst_n && state == ST_IDLE) begin
      req0_ready = req0_valid && !grant1;
      req1_ready = req1_valid && grant1;
    end
  end

  assign accept = req0_ready || req1_ready;

  always_comb begin
    op_sel.a   = grant1 ? req1_a : req0_a;
    op_sel.b   = grant1 ? req1_b : req0_b;
    op_sel.fxn = fxn_t'(grant1 ? req1_fxn : req0_fxn);
    op_sel.id  = grant1;
  end

  always_comb begin
    state_nxt = state;
    rsp_valid = 1'b0;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_EXEC;
      ST_EXEC: state_nxt = ST_RESP;
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= '0;
      last_grant <= 1'b1;
      rsp_data   <= '0;
      rsp_id     <= 1'b0;
`ifdef ALU_ARB_FLAGS_EN
      rsp_zero   <= 1'b0;
      rsp_neg    <= 1'b0;
`endif
    end else begin
      if (accept) begin
        op_q       <= op_sel;
        last_grant <= op_sel.id;
      end
      if (state == ST_EXEC) begin
        rsp_data <= alu_y;
        rsp_id   <= op_q.id;
`ifdef ALU_ARB_FLAGS_EN
        rsp_zero <= (alu_y == '0);
        rsp_neg  <= alu_y[DW-1];
`endif
      end
    end
  end

  alu_arbiter_mini_alu u_alu (
    .a   (op_q.a),
    .b   (op_q.b),
    .fxn (op_q.fxn),
    .y   (alu_y)
  );

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter FAIR, default 1; 1 = round-robin grant, 0 = fixed priority (req0 wins).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 req0_a, req0_b  input  6 each  operands A, B, two's complement.
REQ-007 req0_fxn  input  3  ALU function code (000 A, 001 B, 010 -A, 011 -B, 100 A<B signed, 101 XNOR, 110 A+B, 111 A-B).
REQ-008 req1_valid, req1_ready, req1_a, req1_b, req1_fxn  as REQ-004..007 for requester 1.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_ready  input  1  consumer accepts result.
REQ-011 rsp_data  output  6  ALU result, modulo 2^6.
REQ-012 rsp_id  output  1  requester index owning rsp_data.

Function
REQ-013 FSM states IDLE, EXEC, RESP; the FSM SHALL start in IDLE.
REQ-014 IDLE: reqN_ready = 1 only for the granted requester with reqN_valid=1; all other ready = 0.
REQ-015 Handshake: valid&ready high at an edge captures a, b, fxn, id into registers; FSM -> EXEC.
REQ-016 EXEC: registered operands drive MINI_ALU; output registered into rsp_data/rsp_id at end of cycle; FSM -> RESP.
REQ-017 RESP: rsp_valid = 1; rsp_data, rsp_id stable until rsp_valid&rsp_ready; then FSM -> IDLE.
REQ-018 Latency: rsp_valid rises exactly 2 cycles after the accepting edge; minimum issue interval 3 cycles.
REQ-019 Both ready signals SHALL be 0 in EXEC and RESP; requests are never dropped, only stalled.
REQ-020 FAIR=1: both valid in IDLE -> grant requester other than last_grant; one valid -> grant it; last_grant updates on accept only.
REQ-021 FAIR=0: req0 always wins when both valid.
REQ-022 rsp_ready held low SHALL hold RESP indefinitely with no change to rsp_data/rsp_id.
REQ-023 reqN_valid deasserted without handshake SHALL leave grant pointer and FSM unchanged.
REQ-024 All 8 fxn codes legal; results match MINI_ALU exactly, including overflow wrap (111111+111111 = 111110).

Reset
REQ-025 rst_n low SHALL immediately force: FSM IDLE, rsp_valid 0, rsp_data 000000, rsp_id 0, both ready 0, last_grant 1 (req0 first).
REQ-026 Reset mid-EXEC or mid-RESP SHALL discard the transaction; no response emitted after release.
REQ-027 First edge after rst_n release behaves as IDLE.

Configuration
REQ-028 Macro ALU_ARB_FLAGS_EN defined: add outputs rsp_zero (rsp_data == 0) and rsp_neg (rsp_data[5]), registered with rsp_data, reset 0.
REQ-029 ALU_ARB_FLAGS_EN undefined: those ports and registers absent; all other behaviour identical.

Structure
REQ-030 Shared package holds fxn code constants (FXN_PASS_A..FXN_SUB), data width 6, FSM state encoding.
REQ-031 One sub-module: the existing MINI_ALU, instantiated once; no other datapath logic duplicated.

Verification
REQ-032 req0 a=000101 b=001111 fxn=110 -> rsp_data 010100, rsp_id 0, rsp_valid 2 cycles after accept.
REQ-033 After reset, both valid simultaneously (FAIR=1) -> req0 served first, then req1; FAIR=0 with req0 held valid -> req1 never granted.
REQ-034 req1 a=100101 b=101111 fxn=100 -> rsp_data 000001, rsp_id 1.
REQ-035 rsp_ready low 5 cycles in RESP -> rsp_data stable, both ready 0 throughout; handshake on cycle 6 returns IDLE.
REQ-036 rst_n pulsed low during EXEC -> rsp_valid stays 0, next accepted request is req0.
REQ-037 ALU_ARB_FLAGS_EN: a=b=111111 fxn=111 -> rsp_data 000000, rsp_zero 1, rsp_neg 0; fxn=010 a=000001 -> 111111, rsp_neg 1.
